// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// One shift-add multiply or restoring-divide iteration on unsigned magnitudes.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the step.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    nxt_hi  = acc_hi;
    nxt_lo  = acc_lo;
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    if (is_div) begin
      // Remainder stays below the divisor, so bit WIDTH of diff is the borrow.
      if (!diff[WIDTH]) begin
        nxt_hi = diff[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO, committed on result handshake.
// Latency: accept at edge N gives out_valid after edge N+WIDTH+3; MTHI/MTLO write at the accept edge.
// Backpressure: result held in DONE while out_ready is low; in_ready is low whenever not idle or cancel.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               op_div;
  logic               op_signed;
  logic               neg_main;
  logic               neg_rem;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign in_ready  = (state == ST_IDLE) && !cancel;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_main ? -prod : prod;
  assign quo_fix  = neg_main ? -acc_lo : acc_lo;
  assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

  muldiv_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .is_div (op_div),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .operand(opb),
    .nxt_hi (step_hi),
    .nxt_lo (step_lo)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && !in_op[2]) state_nxt = ST_PREP;
      ST_PREP: state_nxt = ST_CALC;
      ST_CALC: if (cnt == '0) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (cancel) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi        <= '0;
      lo        <= '0;
      out_hi    <= '0;
      out_lo    <= '0;
      opa       <= '0;
      opb       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
      neg_main  <= 1'b0;
      neg_rem   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (in_op == MD_MTHI) hi <= in_a;
            if (in_op == MD_MTLO) lo <= in_a;
            opa       <= in_a;
            opb       <= in_b;
            op_div    <= in_op[1];
            op_signed <= !in_op[0];
          end
        end
        ST_PREP: begin
          // Iterate on magnitudes; signs are restored in FIX.
          neg_main <= op_signed && (opa[WIDTH-1] ^ opb[WIDTH-1]);
          neg_rem  <= op_signed && opa[WIDTH-1];
          acc_lo   <= (op_signed && opa[WIDTH-1]) ? -opa : opa;
          opb      <= (op_signed && opb[WIDTH-1]) ? -opb : opb;
          acc_hi   <= '0;
          cnt      <= CNT_W'(WIDTH);
        end
        ST_CALC: begin
          if (cnt != '0) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt - CNT_W'(1);
          end
        end
        ST_FIX: begin
          out_hi <= op_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          out_lo <= op_div ? quo_fix : prod_fix[WIDTH-1:0];
        end
        ST_DONE: begin
          if (out_ready && !cancel) begin
            hi <= out_hi;
            lo <= out_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded bench for muldiv_unit at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        iv32, ir32, cn32, ov32, or32, bz32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, oh32, ol32, h32, l32;
  logic        iv8, ir8, cn8, ov8, or8, bz8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, oh8, ol8, h8, l8;

  muldiv_unit #(.WIDTH(32)) u32 (
    .clk(clk), .resetn(resetn), .in_valid(iv32), .in_ready(ir32), .in_op(op32),
    .in_a(a32), .in_b(b32), .cancel(cn32), .out_valid(ov32), .out_ready(or32),
    .out_hi(oh32), .out_lo(ol32), .hi(h32), .lo(l32), .busy(bz32)
  );

  muldiv_unit #(.WIDTH(8)) u8 (
    .clk(clk), .resetn(resetn), .in_valid(iv8), .in_ready(ir8), .in_op(op8),
    .in_a(a8), .in_b(b8), .cancel(cn8), .out_valid(ov8), .out_ready(or8),
    .out_hi(oh8), .out_lo(ol8), .hi(h8), .lo(l8), .busy(bz8)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          acc;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } dir_t;

  exp_t q32[$];
  exp_t q8[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [31:0] mh32 = '0, ml32 = '0, mh8 = '0, ml8 = '0;
  bit prev_ov32 = 0, prev_ov8 = 0;

  dir_t dirs[7] = '{
    '{MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1},
    '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
    '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'hE},
    '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD},
    '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000},
    '{MD_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF},
    '{MD_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'd1}
  };

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on w-bit values.
  function automatic exp_t model(input int w, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    logic [63:0] mask, ua, ub, p;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    e.hi = '0;
    e.lo = '0;
    e.acc = 0;
    p = '0;
    case (op)
      MD_MULT, MD_MULTU: begin
        p = (op == MD_MULT) ? 64'(sa * sb) : ua * ub;
        e.hi = 32'((p >> w) & mask);
        e.lo = 32'(p & mask);
      end
      MD_DIV: begin
        if (sb == 0) begin
          e.lo = 32'((sa < 0) ? 64'd1 : mask);
          e.hi = 32'(ua);
        end else begin
          e.lo = 32'(64'(sa / sb) & mask);
          e.hi = 32'(64'(sa % sb) & mask);
        end
      end
      MD_DIVU: begin
        if (ub == 0) begin
          e.lo = 32'(mask);
          e.hi = 32'(ua);
        end else begin
          e.lo = 32'(ua / ub);
          e.hi = 32'(ua % ub);
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Called on a negedge; drives one request and returns on the negedge after acceptance.
  task automatic issue(input bit w8, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit keep);
    exp_t e;
    int n = 0;
    while (!(w8 ? ir8 : ir32) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL issue_timeout: in_ready 0 for %0d cycles, required 1", n);
    end
    e = model(w8 ? 8 : 32, op, a, b);
    e.acc = cyc + 1;
    if (w8) begin
      iv8 = 1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      iv32 = 1; op32 = op; a32 = a; b32 = b;
    end
    if (keep) begin
      if (op == MD_MTHI) begin
        if (w8) mh8 = a & 32'hFF; else mh32 = a;
      end else if (op == MD_MTLO) begin
        if (w8) ml8 = a & 32'hFF; else ml32 = a;
      end else if (!op[2]) begin
        if (w8) begin q8.push_back(e); mh8 = e.hi; ml8 = e.lo; end
        else begin q32.push_back(e); mh32 = e.hi; ml32 = e.lo; end
      end
    end
    @(negedge clk);
    iv8 = 0;
    iv32 = 0;
  endtask

  task automatic wait_idle(input bit w8);
    int n = 0;
    while ((w8 ? (bz8 || q8.size() > 0) : (bz32 || q32.size() > 0)) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      compared++;
      mismatched++;
      $display("FAIL idle_timeout: busy after %0d cycles, required idle", n);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (ov32 && !prev_ov32) begin
      if (q32.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_out_valid32: got 1 required 0");
      end else check("latency32", 32'(cyc - q32[0].acc), 32'd35);
    end
    if (ov32 && or32 && q32.size() > 0) begin
      e = q32.pop_front();
      check("out_hi32", oh32, e.hi);
      check("out_lo32", ol32, e.lo);
    end
    prev_ov32 = ov32;
    if (ov8 && !prev_ov8) begin
      if (q8.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_out_valid8: got 1 required 0");
      end else check("latency8", 32'(cyc - q8[0].acc), 32'd11);
    end
    if (ov8 && or8 && q8.size() > 0) begin
      e = q8.pop_front();
      check("out_hi8", {24'd0, oh8}, e.hi);
      check("out_lo8", {24'd0, ol8}, e.lo);
    end
    prev_ov8 = ov8;
  end

  initial begin
    logic [31:0] old_lo;
    int n;
    resetn = 1; iv32 = 0; cn32 = 0; or32 = 1; op32 = '0; a32 = '0; b32 = '0;
    iv8 = 0; cn8 = 0; or8 = 1; op8 = '0; a8 = '0; b8 = '0;
    #2 resetn = 0;
    repeat (2) @(negedge clk);
    check("rst_hi32", h32, 0);
    check("rst_lo32", l32, 0);
    check("rst_out_lo32", ol32, 0);
    check("rst_flags32", {29'd0, ov32, bz32, ir32}, 32'd1);
    check("rst_flags8", {29'd0, ov8, bz8, ir8}, 32'd1);
    resetn = 1;
    @(negedge clk);

    foreach (dirs[i]) begin
      issue(0, dirs[i].op, dirs[i].a, dirs[i].b, 1);
      wait_idle(0);
      check($sformatf("dir%0d_hi", i), h32, dirs[i].eh);
      check($sformatf("dir%0d_lo", i), l32, dirs[i].el);
    end

    issue(0, MD_MTHI, 32'h1234, 0, 1);
    issue(0, MD_MTLO, 32'h5678, 0, 1);
    check("mthi", h32, 32'h1234);
    check("mtlo", l32, 32'h5678);

    issue(0, 3'd6, 32'h1, 32'h2, 1);
    issue(0, 3'd7, 32'h3, 32'h4, 1);
    check("op67_hi", h32, 32'h1234);
    check("op67_busy", {31'd0, bz32}, 0);

    // cancel in IDLE blocks acceptance
    cn32 = 1; iv32 = 1; op32 = MD_MTHI; a32 = 32'h5555;
    #1 check("cancel_in_ready", {31'd0, ir32}, 0);
    @(negedge clk);
    cn32 = 0; iv32 = 0;
    check("cancel_idle_hi", h32, 32'h1234);

    issue(0, MD_MTHI, 32'hAAAA, 0, 1);
    issue(0, MD_MTLO, 32'hAAAA, 0, 1);
    issue(0, MD_DIVU, 32'd9, 32'd2, 0);
    repeat (9) @(negedge clk);
    cn32 = 1;
    @(negedge clk);
    cn32 = 0;
    check("cancel_busy", {31'd0, bz32}, 0);
    check("cancel_ov", {31'd0, ov32}, 0);
    repeat (40) @(negedge clk);
    check("cancel_hi", h32, 32'hAAAA);
    check("cancel_lo", l32, 32'hAAAA);
    issue(0, MD_MULT, 32'd2, 32'd3, 1);
    wait_idle(0);
    check("after_cancel_lo", l32, 32'd6);

    or32 = 0;
    old_lo = ml32;
    issue(0, MD_MULTU, 32'd3, 32'd4, 1);
    n = 0;
    while (!ov32 && n < 100) begin @(negedge clk); n++; end
    check("bp_reached_done", {31'd0, ov32}, 1);
    repeat (5) begin
      check("bp_out_lo", ol32, 32'd12);
      check("bp_lo_held", l32, old_lo);
      check("bp_in_ready", {31'd0, ir32}, 0);
      @(negedge clk);
    end
    check("bp_lo_pre_hs", l32, old_lo);
    or32 = 1;
    @(negedge clk);
    check("bp_lo_post_hs", l32, 32'd12);
    wait_idle(0);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] b;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      issue(0, 3'($urandom_range(0, 3)), $urandom, b, 1);
    end
    wait_idle(0);
    check("rand_hi32", h32, mh32);
    check("rand_lo32", l32, ml32);

    issue(1, MD_MULT, 32'h80, 32'h80, 1);
    wait_idle(1);
    check("w8_mult_hi", {24'd0, h8}, 32'h40);
    check("w8_mult_lo", {24'd0, l8}, 32'h00);
    issue(1, MD_DIVU, 32'hFF, 32'h10, 1);
    wait_idle(1);
    check("w8_divu_hi", {24'd0, h8}, 32'h0F);
    check("w8_divu_lo", {24'd0, l8}, 32'h0F);
    for (int i = 0; i < 20; i++) begin
      issue(1, 3'($urandom_range(0, 3)), $urandom,
            ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom, 1);
    end
    wait_idle(1);
    check("rand_hi8", {24'd0, h8}, mh8);
    check("rand_lo8", {24'd0, l8}, ml8);

    // reset mid-operation leaves no partial result
    issue(1, MD_MTHI, 32'h5A, 0, 1);
    issue(1, MD_MULTU, 32'hFF, 32'hFF, 0);
    repeat (4) @(negedge clk);
    resetn = 0;
    #1;
    check("midrst_busy8", {31'd0, bz8}, 0);
    check("midrst_hi8", {24'd0, h8}, 0);
    check("midrst_out_lo8", {24'd0, ol8}, 0);
    @(negedge clk);
    resetn = 1;
    repeat (20) @(negedge clk);
    check("midrst_lo8", {24'd0, l8}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
